// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter: requester counts and FSM encoding.
package com_bus_arbiter_pkg;

    localparam int ARB_N_PROC  = 8;
    localparam int ARB_N_SNOOP = 4;
    localparam int HOLD_CNT_W  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module com_bus_arbiter_rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    int   pos;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos   = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Grant side of the Com_Bus_Req/Gnt handshake: round-robin processor tenure with
// nested snoop grants, one-cycle turnaround and optional tenure timeout.
//   state    | meaning
//   ARB_IDLE | no tenure; arbitrate eligible processor requests
//   ARB_OWN  | processor grant held; snoop sub-arbitration active
//   ARB_GAP  | one turnaround cycle with all grants low
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
#(
    parameter int N_PROC   = ARB_N_PROC,
    parameter int N_SNOOP  = ARB_N_SNOOP,
    parameter int MAX_HOLD = 0,
    parameter int OWNER_W  = $clog2(N_PROC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PROC-1:0]  Com_Bus_Req_proc,
    output logic [N_PROC-1:0]  Com_Bus_Gnt_proc,
    input  logic [N_SNOOP-1:0] Com_Bus_Req_snoop,
    output logic [N_SNOOP-1:0] Com_Bus_Gnt_snoop,
    output logic               Bus_busy,
    output logic [OWNER_W-1:0] Bus_owner,
    output logic               Bus_timeout
);

    localparam int SNOOP_W = (N_SNOOP > 1) ? $clog2(N_SNOOP) : 1;
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(MAX_HOLD);

    arb_state_t              state_q, state_d;
    logic [N_PROC-1:0]       gnt_p_q, gnt_p_d;
    logic [N_PROC-1:0]       stale_q, stale_d;
    logic [N_SNOOP-1:0]      gnt_s_q, gnt_s_d;
    logic [OWNER_W-1:0]      owner_q, owner_d;
    logic [OWNER_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                    busy_q, busy_d;
    logic                    tmo_q, tmo_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;

    logic [N_PROC-1:0]       proc_elig, proc_oh;
    logic [OWNER_W-1:0]      proc_idx;
    logic [N_SNOOP-1:0]      snp_req_m, snp_oh;
    logic [SNOOP_W-1:0]      snp_idx;

    // A requester revoked by timeout stays ineligible until it drops its request.
    assign proc_elig = Com_Bus_Req_proc & ~stale_q;

    com_bus_arbiter_rr_pick #(.N(N_PROC), .W(OWNER_W)) u_proc_pick (
        .req (proc_elig),
        .ptr (rr_ptr_q),
        .gnt (proc_oh),
        .idx (proc_idx)
    );

    always_comb begin
        snp_req_m = Com_Bus_Req_snoop;
        for (int i = 0; i < N_SNOOP; i++) begin
            if (owner_q == OWNER_W'(i)) snp_req_m[i] = 1'b0;
        end
    end

    com_bus_arbiter_rr_pick #(.N(N_SNOOP), .W(SNOOP_W)) u_snoop_pick (
        .req (snp_req_m),
        .ptr (SNOOP_W'(0)),
        .gnt (snp_oh),
        .idx (snp_idx)
    );

    assign hold_inc = (hold_cnt_q == {HOLD_CNT_W{1'b1}}) ? hold_cnt_q
                                                         : hold_cnt_q + HOLD_CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        gnt_p_d    = gnt_p_q;
        gnt_s_d    = gnt_s_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        busy_d     = busy_q;
        tmo_d      = 1'b0;
        hold_cnt_d = hold_cnt_q;
        stale_d    = stale_q & Com_Bus_Req_proc;
        case (state_q)
            ARB_IDLE: begin
                if (|proc_oh) begin
                    state_d    = ARB_OWN;
                    gnt_p_d    = proc_oh;
                    owner_d    = proc_idx;
                    rr_ptr_d   = (proc_idx == OWNER_W'(N_PROC - 1)) ? '0
                                                                   : proc_idx + OWNER_W'(1);
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ARB_OWN: begin
                hold_cnt_d = hold_inc;
                if (!Com_Bus_Req_proc[owner_q]) begin
                    state_d = ARB_GAP;
                    gnt_p_d = '0;
                    gnt_s_d = '0;
                    busy_d  = 1'b0;
                end else if (MAX_HOLD != 0 && hold_inc == HOLD_LIM) begin
                    state_d          = ARB_GAP;
                    gnt_p_d          = '0;
                    gnt_s_d          = '0;
                    busy_d           = 1'b0;
                    tmo_d            = 1'b1;
                    stale_d[owner_q] = 1'b1;
                end else if (|gnt_s_q) begin
                    // A cleared snoop grant leaves one low cycle before the next pick.
                    if (!(|(gnt_s_q & Com_Bus_Req_snoop))) gnt_s_d = '0;
                end else if (|snp_oh) begin
                    gnt_s_d          = '0;
                    gnt_s_d[snp_idx] = 1'b1;
                end
            end
            ARB_GAP: state_d = ARB_IDLE;
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            gnt_p_q    <= '0;
            gnt_s_q    <= '0;
            stale_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_p_q    <= gnt_p_d;
            gnt_s_q    <= gnt_s_d;
            stale_q    <= stale_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_p_q;
    assign Com_Bus_Gnt_snoop = gnt_s_q;
    assign Bus_busy          = busy_q;
    assign Bus_owner         = owner_q;
    assign Bus_timeout       = tmo_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed bench for com_bus_arbiter: one instance with MAX_HOLD=5, one with timeout off.
module tb_com_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_p;
    logic [3:0] req_s;
    logic [7:0] gnt_p, gnt_p2;
    logic [3:0] gnt_s, gnt_s2;
    logic       busy, busy2, tmo, tmo2;
    logic [2:0] owner, owner2;

    int n_cmp = 0;
    int n_err = 0;
    int e;
    logic [7:0] exp_oh;

    always #5 clk = ~clk;

    com_bus_arbiter #(.N_PROC(8), .N_SNOOP(4), .MAX_HOLD(5), .OWNER_W(3)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Com_Bus_Req_proc  (req_p),
        .Com_Bus_Gnt_proc  (gnt_p),
        .Com_Bus_Req_snoop (req_s),
        .Com_Bus_Gnt_snoop (gnt_s),
        .Bus_busy          (busy),
        .Bus_owner         (owner),
        .Bus_timeout       (tmo)
    );

    com_bus_arbiter #(.N_PROC(8), .N_SNOOP(4), .MAX_HOLD(0), .OWNER_W(3)) u_dut_nh (
        .clk               (clk),
        .rst_n             (rst_n),
        .Com_Bus_Req_proc  (req_p),
        .Com_Bus_Gnt_proc  (gnt_p2),
        .Com_Bus_Req_snoop (req_s),
        .Com_Bus_Gnt_snoop (gnt_s2),
        .Bus_busy          (busy2),
        .Bus_owner         (owner2),
        .Bus_timeout       (tmo2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_p = '0;
        req_s = '0;
        step();
        step();
        chk("rst_gnt_p", gnt_p, 8'h00);
        chk("rst_gnt_s", 8'(gnt_s), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_owner", 8'(owner), 8'h00);
        chk("rst_tmo", 8'(tmo), 8'h00);
        rst_n = 1'b1;

        // single request, release and turnaround
        req_p = 8'h04;
        step();
        chk("single_gnt", gnt_p, 8'h04);
        chk("single_owner", 8'(owner), 8'd2);
        chk("single_busy", 8'(busy), 8'h01);
        step();
        chk("single_hold", gnt_p, 8'h04);
        req_p = 8'h00;
        step();
        chk("single_gap_gnt", gnt_p, 8'h00);
        chk("single_gap_busy", 8'(busy), 8'h00);
        chk("single_owner_keep", 8'(owner), 8'd2);
        step();
        chk("single_idle_gnt", gnt_p, 8'h00);

        // fairness: all requesting, rr_ptr starts at 3
        e = 3;
        req_p = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_oh = 8'h01 << e;
            step();
            chk("fair_gnt", gnt_p, exp_oh);
            chk("fair_owner", 8'(owner), 8'(e));
            step();
            step();
            chk("fair_hold", gnt_p, exp_oh);
            req_p[e] = 1'b0;
            step();
            chk("fair_gap", gnt_p, 8'h00);
            req_p[e] = 1'b1;
            step();
            chk("fair_idle", gnt_p, 8'h00);
            e = (e + 1) % 8;
        end
        req_p = 8'h00;

        // nested snoop with owner 1 (rr_ptr is 4)
        req_p = 8'h02;
        step();
        chk("nest_gnt", gnt_p, 8'h02);
        chk("nest_owner", 8'(owner), 8'd1);
        req_s = 4'b0110;
        step();
        chk("nest_snoop_gnt", 8'(gnt_s), 8'h04);
        req_s = 4'b0010;
        step();
        chk("nest_snoop_drop", 8'(gnt_s), 8'h00);
        step();
        chk("nest_snoop_masked", 8'(gnt_s), 8'h00);
        chk("nest_owner_hold", gnt_p, 8'h02);
        req_s = 4'b1010;
        step();
        chk("nest_snoop_b3", 8'(gnt_s), 8'h08);
        req_p = 8'h00;
        step();
        chk("drop_both_p", gnt_p, 8'h00);
        chk("drop_both_s", 8'(gnt_s), 8'h00);
        step();
        chk("snoop_ign_idle", 8'(gnt_s), 8'h00);
        step();
        chk("snoop_ign_idle2", 8'(gnt_s), 8'h00);
        req_s = 4'b0000;

        // simultaneous proc requests, rr_ptr is 2 -> wrap to 0
        req_p = 8'h03;
        req_s = 4'b0010;
        step();
        chk("simul_gnt", gnt_p, 8'h01);
        chk("simul_owner", 8'(owner), 8'd0);
        chk("simul_snoop_wait", 8'(gnt_s), 8'h00);
        step();
        chk("simul_snoop_gnt", 8'(gnt_s), 8'h02);
        req_p = 8'h00;
        req_s = 4'b0000;
        step();
        chk("simul_gap", gnt_p, 8'h00);
        step();

        // timeout, rr_ptr is 1 -> requester 5 first
        req_p = 8'h60;
        step();
        chk("to_gnt", gnt_p, 8'h20);
        chk("to_owner", 8'(owner), 8'd5);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("to_hold", gnt_p, 8'h20);
            chk("to_no_pulse", 8'(tmo), 8'h00);
        end
        step();
        chk("to_revoked", gnt_p, 8'h00);
        chk("to_pulse", 8'(tmo), 8'h01);
        chk("to_busy", 8'(busy), 8'h00);
        chk("nh_still_gnt", gnt_p2, 8'h20);
        chk("nh_no_pulse", 8'(tmo2), 8'h00);
        chk("nh_busy", 8'(busy2), 8'h01);
        step();
        chk("to_pulse_end", 8'(tmo), 8'h00);
        chk("to_idle_gnt", gnt_p, 8'h00);
        step();
        chk("to_next_gnt", gnt_p, 8'h40);
        chk("to_next_owner", 8'(owner), 8'd6);
        req_p = 8'h20;
        step();
        chk("to_next_gap", gnt_p, 8'h00);
        step();
        step();
        chk("stale_masked", gnt_p, 8'h00);
        chk("stale_busy", 8'(busy), 8'h00);
        req_p = 8'h00;
        step();
        chk("stale_dropped", gnt_p, 8'h00);
        req_p = 8'h20;
        step();
        chk("stale_regrant", gnt_p, 8'h20);
        chk("stale_regrant_own", 8'(owner), 8'd5);

        // reset in the middle of a tenure with a snoop grant
        req_s = 4'b0001;
        step();
        chk("pre_rst_snoop", 8'(gnt_s), 8'h01);
        rst_n = 1'b0;
        step();
        chk("mid_rst_gnt_p", gnt_p, 8'h00);
        chk("mid_rst_gnt_s", 8'(gnt_s), 8'h00);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        chk("mid_rst_owner", 8'(owner), 8'h00);
        chk("mid_rst_tmo", 8'(tmo), 8'h00);
        chk("mid_rst_nh_gnt", gnt_p2, 8'h00);
        chk("mid_rst_nh_owner", 8'(owner2), 8'h00);
        rst_n = 1'b1;
        req_s = 4'b0000;
        req_p = 8'h80;
        step();
        chk("post_rst_gnt", gnt_p, 8'h80);
        chk("post_rst_owner", 8'(owner), 8'd7);
        chk("post_rst_snoop", 8'(gnt_s2), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
